// File: rtl/adc_packetizer.sv
// adc_packetizer: packs decimated multi-channel ADC samples into FIFO words,
// frames the words into fixed-length packets with an optional sequence
// number header, and hands each packet to the W5500 controller using a
// pkt_ready / pkt_done handshake. Words that complete while the downstream
// FIFO is full are dropped and counted.
module adc_packetizer #(
    parameter int ADC_BITS  = 12,
    parameter int CHANNELS  = 1,
    parameter int SAMPLES   = 4,
    parameter int PKT_WORDS = 245,
    parameter int HEADER_EN = 1,
    parameter int DECIM_W   = 8
) (
    input  logic                                  sys_clk,
    input  logic                                  reset_n,
    input  logic                                  enable,
    input  logic [DECIM_W-1:0]                    decim,
    input  logic [CHANNELS*ADC_BITS-1:0]          adc_data,
    input  logic                                  adc_valid,
    input  logic                                  fifo_full,
    output logic                                  fifo_wr_en,
    output logic [ADC_BITS*CHANNELS*SAMPLES-1:0]  fifo_data,
    output logic                                  pkt_ready,
    input  logic                                  pkt_done,
    output logic                                  busy,
    output logic [15:0]                           seq_num,
    output logic [15:0]                           drop_cnt
);

    localparam int SLOT_W     = CHANNELS * ADC_BITS;
    localparam int FIFO_W     = SLOT_W * SAMPLES;
    localparam int SLOT_CNT_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_WAIT_TX = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [15:0]             word_cnt_reg;
    logic [SLOT_CNT_W-1:0]   slot_cnt_reg;
    logic [DECIM_W-1:0]      dc_reg;
    logic                    header_pending_reg;
    logic                    word_pending_reg;
    logic [FIFO_W-1:0]       shift_reg;
    logic [FIFO_W-1:0]       out_word_reg;
    logic [15:0]             seq_num_reg;
    logic [15:0]             drop_cnt_reg;

    logic                    start_fill;
    logic                    write_hdr;
    logic                    write_word;
    logic                    drop_word;
    logic                    last_word;
    logic                    seq_inc;
    logic [FIFO_W-1:0]       header_word;
    logic [FIFO_W-1:0]       shifted_word;
    logic                    sample_gate;
    logic                    sample_take;
    logic                    word_done;

    // Shift network: the new sample enters slot 0 (LSBs) and every older
    // slot moves one position toward the MSBs, so the oldest sample of a
    // completed word sits in the top slot.
    generate
        for (genvar gi = 0; gi < SAMPLES; gi++) begin : g_slot
            if (gi == 0) begin : g_first
                assign shifted_word[SLOT_W-1:0] = adc_data;
            end else begin : g_rest
                assign shifted_word[gi*SLOT_W +: SLOT_W] = shift_reg[(gi-1)*SLOT_W +: SLOT_W];
            end
        end
    endgenerate

    // Header word: sequence number in the top 16 bits, zeros below.
    always_comb begin
        header_word = '0;
        header_word[FIFO_W-1 -: 16] = seq_num_reg;
    end

    // Samples are only looked at while filling, after the header is out,
    // and never on the cycle the packet's last word leaves.
    assign sample_gate = adc_valid && (state_reg == ST_FILL) && !header_pending_reg && !last_word;
    assign sample_take = sample_gate && (dc_reg == '0);
    assign word_done   = sample_take && (slot_cnt_reg == SLOT_CNT_W'(SAMPLES - 1));

    assign busy     = reset_n && (state_reg != ST_IDLE);
    assign seq_num  = seq_num_reg;
    assign drop_cnt = drop_cnt_reg;

    // FSM next-state and write/handshake decode; everything held low in reset.
    always_comb begin
        state_next = state_reg;
        start_fill = 1'b0;
        write_hdr  = 1'b0;
        write_word = 1'b0;
        drop_word  = 1'b0;
        last_word  = 1'b0;
        seq_inc    = 1'b0;
        fifo_wr_en = 1'b0;
        fifo_data  = '0;
        pkt_ready  = 1'b0;
        if (reset_n) begin
            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        state_next = ST_FILL;
                        start_fill = 1'b1;
                    end
                end
                ST_FILL: begin
                    // Header and a completed data word are never pending together,
                    // since packing only starts once the header has been written.
                    if (header_pending_reg) begin
                        if (!fifo_full) begin
                            write_hdr  = 1'b1;
                            fifo_wr_en = 1'b1;
                            fifo_data  = header_word;
                        end
                    end else if (word_pending_reg) begin
                        if (!fifo_full) begin
                            write_word = 1'b1;
                            fifo_wr_en = 1'b1;
                            fifo_data  = out_word_reg;
                        end else begin
                            drop_word = 1'b1;
                        end
                    end
                    last_word = (write_hdr || write_word) && (word_cnt_reg == 16'(PKT_WORDS - 1));
                    if (last_word) begin
                        pkt_ready  = 1'b1;
                        state_next = ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    if (pkt_done) begin
                        seq_inc = 1'b1;
                        if (enable) begin
                            state_next = ST_FILL;
                            start_fill = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Packet framing: word count, slot count, decimation and pending flags.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            word_cnt_reg       <= '0;
            slot_cnt_reg       <= '0;
            dc_reg             <= '0;
            header_pending_reg <= 1'b0;
            word_pending_reg   <= 1'b0;
        end else if (start_fill) begin
            word_cnt_reg       <= '0;
            slot_cnt_reg       <= '0;
            dc_reg             <= '0;
            header_pending_reg <= (HEADER_EN != 0);
            word_pending_reg   <= 1'b0;
        end else begin
            if (write_hdr || write_word) begin
                word_cnt_reg <= word_cnt_reg + 16'd1;
            end
            if (write_hdr) begin
                header_pending_reg <= 1'b0;
            end
            // A pending word lives for exactly one cycle: written or dropped.
            // A word completing on that same cycle re-arms the flag.
            if (write_word || drop_word) begin
                word_pending_reg <= 1'b0;
            end
            if (word_done) begin
                word_pending_reg <= 1'b1;
            end
            if (sample_gate) begin
                if (dc_reg == '0) begin
                    dc_reg <= decim;
                end else begin
                    dc_reg <= dc_reg - DECIM_W'(1);
                end
            end
            if (sample_take) begin
                slot_cnt_reg <= word_done ? '0 : slot_cnt_reg + SLOT_CNT_W'(1);
            end
        end
    end

    // Sample shift register and the separate output word register, so the
    // next word can start packing while the previous one is being written.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            shift_reg    <= '0;
            out_word_reg <= '0;
        end else begin
            if (sample_take) begin
                shift_reg <= shifted_word;
            end
            if (word_done) begin
                out_word_reg <= shifted_word;
            end
        end
    end

    // Sequence number (wraps) and saturating drop counter.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            seq_num_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (seq_inc) begin
                seq_num_reg <= seq_num_reg + 16'd1;
            end
            if (drop_word && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

endmodule

// File: doc/adc_packetizer.md
Name: adc_packetizer

Overview:
- Next-generation ADC-to-FIFO packer for the AD9226/W5500 capture path.
- Accepts multi-channel ADC samples with programmable decimation and packs SAMPLES samples into one FIFO word.
- Frames words into UDP-sized packets of PKT_WORDS, with an optional sequence-number header word.
- Hands each packet to the W5500 controller using a ready/done handshake, and counts FIFO-overflow drops.

Parameters:
- ADC_BITS, 12: bits per channel sample.
- CHANNELS, 1: channels captured per sample strobe; one sample slot = CHANNELS*ADC_BITS bits.
- SAMPLES, 4: sample slots per FIFO word. FIFO_W = ADC_BITS*CHANNELS*SAMPLES, required ≥ 16.
- PKT_WORDS, 245: FIFO words per packet, header included. Range 2..65535.
- HEADER_EN, 1: 1 = first word of every packet is a header word.
- DECIM_W, 8: width of the decimation control.

Ports:
- sys_clk, in, 1: clock.
- reset_n, in, 1: synchronous, active-low reset.
- enable, in, 1: capture enable.
- decim, in, DECIM_W: keep 1 of every (decim+1) valid samples.
- adc_data, in, CHANNELS*ADC_BITS: channel 0 in the LSBs.
- adc_valid, in, 1: sample strobe.
- fifo_full, in, 1: downstream FIFO full.
- fifo_wr_en, out, 1: one-cycle write strobe.
- fifo_data, out, FIFO_W: word to write; valid while fifo_wr_en=1.
- pkt_ready, out, 1: one-cycle pulse, packet complete in FIFO.
- pkt_done, in, 1: W5500 controller has consumed the packet.
- busy, out, 1: high in FILL and WAIT_TX.
- seq_num, out, 16: sequence number of the packet currently being filled.
- drop_cnt, out, 16: saturating count of words dropped on fifo_full.

Behaviour:
- Reset: all outputs 0; state IDLE; word, slot, decimation counters, seq_num and drop_cnt cleared. Reset mid-packet abandons the packet; no pkt_ready is issued.
- States:
  - IDLE: samples ignored. enable=1 → FILL with word_cnt=0, slot=0, decimation counter=0.
  - FILL: packing. When word_cnt reaches PKT_WORDS → WAIT_TX, with pkt_ready pulsed on the same cycle as that transition.
  - WAIT_TX: samples discarded, not counted as drops. pkt_done=1 → seq_num+1 (wraps FFFF→0000); then FILL if enable=1, else IDLE. pkt_done is ignored in IDLE and FILL.
- enable deasserted during FILL: the packet still completes; the return to IDLE happens only after pkt_done.
- Header (HEADER_EN=1):
  - On entry to FILL with word_cnt=0, the first write is fifo_data = {seq_num, (FIFO_W-16) zeros}. It is issued on the first cycle fifo_full=0 and counts as one word.
  - Sample packing starts only after the header is written; samples arriving before then are discarded.
  - With fifo_full held, the header stays pending; it is never dropped.
- Decimation:
  - Counter dc. On adc_valid in FILL: if dc==0, the sample is accepted and dc loads decim; otherwise dc decrements.
  - decim=0 accepts every sample. decim changes take effect at the next reload.
- Packing:
  - An accepted sample is shifted in from the LSB end, so the oldest sample ends up in the MSB slot.
  - On the SAMPLES-th accepted sample, the word completes and slot resets to 0.
  - The next cycle: if fifo_full=0, fifo_wr_en=1 with the completed word, and word_cnt+1. If fifo_full=1, the word is dropped, drop_cnt+1 (saturating at FFFF), and word_cnt is unchanged.
  - Latency: last-sample adc_valid to fifo_wr_en = 1 cycle.
  - fifo_full is sampled only at word completion; partial words are never dropped.
- Simultaneous events:
  - An adc_valid on the cycle a word is written is accepted into the next word; a separate output register is used, so no sample is lost.
  - The last word of a packet and a new adc_valid on the same cycle: the sample is discarded, because the state becomes WAIT_TX.
- fifo_wr_en never asserts outside FILL; at most one write per cycle.

Test Plan:
- CHANNELS=1, SAMPLES=4, HEADER_EN=0, PKT_WORDS=3, decim=0, adc_data ramp 1,2,3… every cycle → three writes: 0x001002003004, then 0x005006007008, then 0x00900A00B00C. pkt_ready pulses with the third write; later samples are ignored until pkt_done.
- HEADER_EN=1, PKT_WORDS=2, three packets each acknowledged with pkt_done → the first write of each packet is header 0x0000/0x0001/0x0002 in bits [47:32], lower bits zero. Each packet is header plus one data word.
- decim=2, ramp 1..12 → accepted samples 1,4,7,10 → word 0x00100400700A.
- fifo_full=1 held over two word completions, then released → no writes, drop_cnt=2, and the packet still completes after PKT_WORDS successful writes.
- enable dropped mid-packet → the packet completes and pkt_ready pulses; pkt_done → IDLE, busy=0. Reset_n pulsed mid-FILL → outputs zero, seq_num=0, and no pkt_ready is issued.
- CHANNELS=2, SAMPLES=2, ADC_BITS=12: samples {ch1=0xAAA, ch0=0x111} then {0xBBB, 0x222} → word 0xAAA111BBB222.
